// File: rtl/stream_delay_line.sv
// Clock-enable-gated delay element for aligning data and strobes: either a WIDTH-bit
// register chain (SHIFT) or a down-counter that re-emits a single pulse (SYNC).
module stream_delay_line #(
    parameter int    WIDTH     = 1,
    parameter int    DELAY     = 16,
    parameter string MODE      = "SHIFT",
    parameter string ALLOW_SRL = "YES"
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (MODE != "SHIFT" && MODE != "SYNC") begin : g_bad_mode
            $error("stream_delay_line: unknown MODE '%s'", MODE);
        end
        if (MODE == "SYNC" && WIDTH != 1) begin : g_bad_width
            $error("stream_delay_line: MODE SYNC requires WIDTH 1, got %0d", WIDTH);
        end
        if (DELAY < 0 || DELAY > 1023) begin : g_bad_delay
            $error("stream_delay_line: DELAY %0d outside 0..1023", DELAY);
        end

        if (DELAY == 0) begin : g_bypass
            logic unused_ctl;
            assign unused_ctl = ^{clk, rst, ce};
            assign dout       = din;
        end else if (MODE == "SHIFT") begin : g_shift
            logic [DELAY-1:0][WIDTH-1:0] sr_d;
            logic [DELAY-1:0][WIDTH-1:0] sr_w;

            always_comb begin
                sr_d = sr_w;
                if (ce) begin
                    sr_d[0] = din;
                    for (int k = 1; k < DELAY; k++) begin
                        sr_d[k] = sr_w[k-1];
                    end
                end
            end

            // The attribute is only a mapping hint; both branches behave identically.
            if (ALLOW_SRL == "YES") begin : g_srl
                (* shreg_extract = "yes" *) logic [DELAY-1:0][WIDTH-1:0] sr_q;
                always_ff @(posedge clk) begin
                    if (!rst) sr_q <= '0;
                    else      sr_q <= sr_d;
                end
                assign sr_w = sr_q;
            end else begin : g_ff
                (* shreg_extract = "no" *) logic [DELAY-1:0][WIDTH-1:0] sr_q;
                always_ff @(posedge clk) begin
                    if (!rst) sr_q <= '0;
                    else      sr_q <= sr_d;
                end
                assign sr_w = sr_q;
            end

            assign dout = sr_w[DELAY-1];
        end else if (MODE == "SYNC") begin : g_sync
            localparam int CW = $clog2(DELAY + 1);
            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;

            // A new pulse always reloads, so only the most recent pulse survives.
            always_comb begin
                cnt_d = cnt_q;
                if (ce) begin
                    if (din[0])               cnt_d = CW'(DELAY);
                    else if (cnt_q != '0)     cnt_d = cnt_q - CW'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (!rst) cnt_q <= '0;
                else      cnt_q <= cnt_d;
            end

            assign dout = WIDTH'(cnt_q == CW'(1));
        end else begin : g_none
            logic unused_ctl;
            assign unused_ctl = ^{clk, rst, ce, din};
            assign dout       = '0;
        end
    endgenerate

endmodule

// File: tb/tb_stream_delay_line.sv
// Directed bench for stream_delay_line: SHIFT/SYNC delays, ce gating, reset, DELAY=0 bypass.
module tb_stream_delay_line;

    logic       clk = 1'b0;
    logic       rst;
    logic       ceA, ceB, ceC, ceZ;
    logic [7:0] dinA, dinZ;
    logic       dinB, dinC, dinZs;
    logic [7:0] doutA, doutE, doutZ, doutZn;
    logic       doutB, doutC, doutZs;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    stream_delay_line #(.WIDTH(8), .DELAY(4),  .MODE("SHIFT"), .ALLOW_SRL("YES")) uA
        (.clk(clk), .rst(rst), .ce(ceA), .din(dinA), .dout(doutA));
    stream_delay_line #(.WIDTH(8), .DELAY(4),  .MODE("SHIFT"), .ALLOW_SRL("NO"))  uE
        (.clk(clk), .rst(rst), .ce(ceA), .din(dinA), .dout(doutE));
    stream_delay_line #(.WIDTH(1), .DELAY(16), .MODE("SHIFT"), .ALLOW_SRL("YES")) uB
        (.clk(clk), .rst(rst), .ce(ceB), .din(dinB), .dout(doutB));
    stream_delay_line #(.WIDTH(1), .DELAY(16), .MODE("SYNC"),  .ALLOW_SRL("YES")) uC
        (.clk(clk), .rst(rst), .ce(ceC), .din(dinC), .dout(doutC));
    stream_delay_line #(.WIDTH(8), .DELAY(0),  .MODE("SHIFT"), .ALLOW_SRL("YES")) uZ
        (.clk(clk), .rst(rst), .ce(ceZ), .din(dinZ), .dout(doutZ));
    stream_delay_line #(.WIDTH(8), .DELAY(0),  .MODE("SHIFT"), .ALLOW_SRL("NO"))  uZn
        (.clk(clk), .rst(rst), .ce(ceZ), .din(dinZ), .dout(doutZn));
    stream_delay_line #(.WIDTH(1), .DELAY(0),  .MODE("SYNC"),  .ALLOW_SRL("YES")) uZs
        (.clk(clk), .rst(rst), .ce(ceZ), .din(dinZs), .dout(doutZs));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] expA [10];
        logic [7:0] expR [6];
        logic [7:0] m    [4];
        logic [7:0] e;

        expA = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
        expR = '{8'h08, 8'h09, 8'h0A, 8'h0B, 8'h55, 8'h00};

        // Reset with ce low
        rst = 1'b0;
        ceA = 1'b0; ceB = 1'b0; ceC = 1'b0; ceZ = 1'b0;
        dinA = '0; dinB = 1'b0; dinC = 1'b0; dinZ = '0; dinZs = 1'b0;
        tick();
        tick();
        chk("rst doutA", doutA, 0);
        chk("rst doutE", doutE, 0);
        chk("rst doutB", doutB, 0);
        chk("rst doutC", doutC, 0);
        rst = 1'b1;

        // SHIFT W8 D4: counting stream
        ceA = 1'b1;
        for (int c = 0; c < 10; c++) begin
            dinA = 8'(c + 1);
            #1;
            chk($sformatf("A c%0d", c), doutA, expA[c]);
            chk($sformatf("E c%0d", c), doutE, expA[c]);
            tick();
        end
        // ce low edges hold state
        ceA = 1'b0; dinA = 8'hAA;
        #1; chk("A hold0", doutA, 8'h07); tick();
        #1; chk("A hold1", doutA, 8'h07); tick();
        ceA = 1'b1; dinA = 8'h0B;
        #1; chk("A hold2", doutA, 8'h07); tick();
        #1; chk("A resume", doutA, 8'h08); chk("E resume", doutE, 8'h08);
        ceA = 1'b0; dinA = '0;

        // SHIFT W1 D16 with ce toggling
        for (int k = 0; k < 36; k++) begin
            ceB  = (k % 2 == 0);
            dinB = (k == 0);
            #1;
            chk($sformatf("B k%0d", k), doutB, (k == 31 || k == 32));
            tick();
        end
        ceB = 1'b0; dinB = 1'b0;

        // SYNC D16: isolated pulses
        ceC = 1'b1;
        for (int n = 0; n <= 80; n++) begin
            dinC = (n == 10 || n == 50);
            #1;
            chk($sformatf("C1 n%0d", n), doutC, (n == 26 || n == 66));
            tick();
        end
        // retrigger drops the earlier pulse
        for (int n = 0; n < 40; n++) begin
            dinC = (n == 0 || n == 5);
            #1;
            chk($sformatf("C2 n%0d", n), doutC, (n == 21));
            tick();
        end
        // pulse coinciding with cnt==1
        for (int n = 0; n < 40; n++) begin
            dinC = (n == 0 || n == 16);
            #1;
            chk($sformatf("C3 n%0d", n), doutC, (n == 16 || n == 32));
            tick();
        end

        // Reset with ce low while samples/pulses are in flight
        for (int n = 0; n < 26; n++) begin
            dinA = (n == 0) ? 8'h55 : 8'h00;
            dinC = (n == 0);
            rst  = (n != 4);
            ceA  = (n != 4);
            ceC  = (n != 4);
            #1;
            chk($sformatf("RA n%0d", n), doutA, (n < 5) ? expR[n] : expR[5]);
            chk($sformatf("RC n%0d", n), doutC, 0);
            tick();
        end
        // Reset with ce high beats a coincident din pulse
        for (int n = 0; n < 26; n++) begin
            dinA = '0;
            dinC = (n == 0 || n == 3);
            rst  = (n != 3);
            ceC  = 1'b1;
            #1;
            chk($sformatf("RC2 n%0d", n), doutC, 0);
            tick();
        end
        rst = 1'b1; dinC = 1'b0;

        // Random: SRL YES/NO against a model, DELAY=0 bypass
        m = '{8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 1000; i++) begin
            ceA   = ($urandom % 4) != 0;
            dinA  = 8'($urandom);
            ceZ   = 1'($urandom);
            dinZ  = 8'($urandom);
            dinZs = 1'($urandom);
            #1;
            e = m[3];
            chk($sformatf("rndA i%0d", i), doutA, e);
            chk($sformatf("rndE i%0d", i), doutE, e);
            chk($sformatf("Z i%0d", i), doutZ, dinZ);
            chk($sformatf("Zn i%0d", i), doutZn, dinZ);
            chk($sformatf("Zs i%0d", i), doutZs, dinZs);
            if (ceA) begin
                m[3] = m[2];
                m[2] = m[1];
                m[1] = m[0];
                m[0] = dinA;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
